// File: rtl/stable_sample_filter.sv
// stable_sample_filter
// Debounces a multi-bit bus that may glitch while an upstream carry chain
// ripples. A new value is forwarded to dout only after it has been seen on
// the registered input for STABLE_CYCLES consecutive clocks; each accepted
// change raises upd for one cycle.
//
// Optional build macro GLITCH_COUNT_EN: when defined, a saturating counter of
// rejected transients is built on glitch_cnt (cleared by glitch_clr). When
// undefined, glitch_cnt is tied to zero and glitch_clr is ignored.
module stable_sample_filter #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned GCNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic              glitch_clr,
    output logic [WIDTH-1:0]  dout,
    output logic              upd,
    output logic              settling,
    output logic [GCNT_W-1:0] glitch_cnt
);

    localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
    localparam logic [StabW-1:0] StabTarget = StabW'(STABLE_CYCLES);

    typedef enum logic {
        StStable,
        StSettling
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [StabW-1:0] stab_inc;
    logic             upd_q, upd_d;
    logic             glitch_ev;

    // Input register: isolates the FSM from combinational glitches on din.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
        end else begin
            din_q <= din;
        end
    end

    assign stab_inc = stab_q + 1'b1;

    // Next-state logic: track a candidate value and count how long it holds.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        stab_d    = stab_q;
        dout_d    = dout_q;
        upd_d     = 1'b0;
        glitch_ev = 1'b0;

        unique case (state_q)
            StStable: begin
                if (din_q != dout_q) begin
                    cand_d  = din_q;
                    stab_d  = StabW'(1);
                    state_d = StSettling;
                end
            end
            StSettling: begin
                if (din_q == cand_q) begin
                    if (stab_inc == StabTarget) begin
                        dout_d  = cand_q;
                        upd_d   = 1'b1;
                        stab_d  = '0;
                        state_d = StStable;
                    end else begin
                        stab_d = stab_inc;
                    end
                end else begin
                    // Candidate broke before acceptance: a rejected transient.
                    glitch_ev = 1'b1;
                    if (din_q == dout_q) begin
                        stab_d  = '0;
                        state_d = StStable;
                    end else begin
                        cand_d = din_q;
                        stab_d = StabW'(1);
                    end
                end
            end
            default: begin
                state_d = StStable;
                stab_d  = '0;
            end
        endcase
    end

    // State register; reset discards any pending candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStable;
            cand_q  <= '0;
            stab_q  <= '0;
            dout_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            dout_q  <= dout_d;
            upd_q   <= upd_d;
        end
    end

    assign dout     = dout_q;
    assign upd      = upd_q;
    assign settling = (state_q == StSettling);

`ifdef GLITCH_COUNT_EN
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;

    // Glitch counter next state: clear has priority, then saturating increment.
    always_comb begin
        gcnt_d = gcnt_q;
        if (glitch_clr) begin
            gcnt_d = '0;
        end else if (glitch_ev && !(&gcnt_q)) begin
            gcnt_d = gcnt_q + 1'b1;
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = glitch_ev ^ glitch_clr;
    assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_stable_sample_filter.sv
// Bench for stable_sample_filter: directed scenarios plus a randomized run,
// all checked against a run-length reference model of the filter.
module tb_stable_sample_filter;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STABLE = 4;
    localparam int unsigned GCNT_W = 2;
    localparam int          GMAX   = (1 << GCNT_W) - 1;
`ifdef GLITCH_COUNT_EN
    localparam bit GcntEn = 1'b1;
`else
    localparam bit GcntEn = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  din;
    logic              glitch_clr;
    logic [WIDTH-1:0]  dout;
    logic              upd;
    logic              settling;
    logic [GCNT_W-1:0] glitch_cnt;

    int checks;
    int errors;

    // Reference model: tracks the sampled sequence as runs of equal values.
    int m_dinq;
    int m_prev;
    int m_run;
    int m_dout;
    int m_upd;
    int m_settling;
    int m_gcnt;

    stable_sample_filter #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE),
        .GCNT_W       (GCNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .glitch_clr(glitch_clr),
        .dout      (dout),
        .upd       (upd),
        .settling  (settling),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        int  s;
        bit  glitch;
        if (rst) begin
            m_dinq = 0; m_prev = 0; m_run = STABLE; m_dout = 0;
            m_upd = 0; m_settling = 0; m_gcnt = 0;
        end else begin
            s = m_dinq;
            // A run ends early (rejected) if it differed from the output value.
            glitch = (s != m_prev) && (m_prev != m_dout);
            m_run  = (s == m_prev) ? ((m_run > STABLE) ? m_run : m_run + 1) : 1;
            m_upd  = (m_run == STABLE && s != m_dout) ? 1 : 0;
            if (m_upd == 1) m_dout = s;
            m_settling = (s != m_dout) ? 1 : 0;
            m_prev = s;
            if (GcntEn) begin
                if (glitch_clr) m_gcnt = 0;
                else if (glitch && m_gcnt < GMAX) m_gcnt = m_gcnt + 1;
            end
            m_dinq = int'(din);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; glitch_clr = 1'b0; din = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        din = 4'hA; rst = 1'b1; glitch_clr = 1'b0;
        tick();
        tick();
        checks++;
        if (dout !== 4'h0) begin
            errors++; $display("FAIL reset_dout got %h want 0", dout);
        end
        checks++;
        if (upd !== 1'b0 || settling !== 1'b0) begin
            errors++; $display("FAIL reset_flags got upd=%b settling=%b want 0 0", upd, settling);
        end
        checks++;
        if (glitch_cnt !== '0) begin
            errors++; $display("FAIL reset_gcnt got %0d want 0", glitch_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dout !== 4'h0) begin
            errors++; $display("FAIL reset_release_dout got %h want 0", dout);
        end
    endtask

    task automatic test_clean_step();
        int n_upd;
        int n_set;
        do_reset();
        tick();
        din = 4'h5;
        n_upd = 0; n_set = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (upd === 1'b1) n_upd++;
            if (settling === 1'b1) n_set++;
            if (n == STABLE + 1) begin
                checks++;
                if (dout !== 4'h5 || upd !== 1'b1) begin
                    errors++;
                    $display("FAIL step_accept edge %0d got dout=%h upd=%b want 5 1", n, dout, upd);
                end
            end else if (n < STABLE + 1) begin
                checks++;
                if (dout !== 4'h0) begin
                    errors++; $display("FAIL step_early edge %0d got dout=%h want 0", n, dout);
                end
            end
        end
        checks++;
        if (n_upd != 1) begin
            errors++; $display("FAIL step_upd_count got %0d want 1", n_upd);
        end
        checks++;
        if (n_set != STABLE - 1) begin
            errors++; $display("FAIL step_settling_cycles got %0d want %0d", n_set, STABLE - 1);
        end
    endtask

    task automatic test_short_pulse();
        int n_upd;
        do_reset();
        n_upd = 0;
        din = 4'h3;
        tick(); tick();
        din = 4'h0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (upd === 1'b1) n_upd++;
        end
        checks++;
        if (dout !== 4'h0 || n_upd != 0) begin
            errors++; $display("FAIL pulse_reject got dout=%h upds=%0d want 0 0", dout, n_upd);
        end
        checks++;
        if (int'(glitch_cnt) != (GcntEn ? 1 : 0)) begin
            errors++; $display("FAIL pulse_gcnt got %0d want %0d", glitch_cnt, GcntEn ? 1 : 0);
        end
    endtask

    task automatic test_ripple();
        logic [WIDTH-1:0] seq [4];
        int n_upd;
        seq[0] = 4'h7; seq[1] = 4'h6; seq[2] = 4'h4; seq[3] = 4'h0;
        do_reset();
        n_upd = 0;
        for (int i = 0; i < 4; i++) begin
            din = seq[i];
            tick();
            if (upd === 1'b1) n_upd++;
        end
        din = 4'h8;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (upd === 1'b1) n_upd++;
        end
        checks++;
        if (dout !== 4'h8 || n_upd != 1) begin
            errors++; $display("FAIL ripple_accept got dout=%h upds=%0d want 8 1", dout, n_upd);
        end
        checks++;
        if (int'(glitch_cnt) != (GcntEn ? 3 : 0)) begin
            errors++; $display("FAIL ripple_gcnt got %0d want %0d", glitch_cnt, GcntEn ? 3 : 0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            din = (i % 2 == 0) ? 4'h1 : 4'h2;
            tick();
        end
        tick();
        checks++;
        if (int'(glitch_cnt) != (GcntEn ? GMAX : 0)) begin
            errors++; $display("FAIL sat_gcnt got %0d want %0d", glitch_cnt, GcntEn ? GMAX : 0);
        end
        din = 4'h1;
        tick();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        checks++;
        if (glitch_cnt !== '0) begin
            errors++; $display("FAIL clr_vs_glitch got %0d want 0", glitch_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n_upd;
        do_reset();
        din = 4'h9;
        for (int n = 0; n < STABLE; n++) tick();
        checks++;
        if (settling !== 1'b1) begin
            errors++; $display("FAIL mid_pre_settling got %b want 1", settling);
        end
        rst = 1'b1; din = 4'h0;
        tick();
        rst = 1'b0;
        checks++;
        if (dout !== 4'h0 || upd !== 1'b0 || settling !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got dout=%h upd=%b settling=%b want 0 0 0", dout, upd, settling);
        end
        n_upd = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (upd !== 1'b0 || dout !== 4'h0 || glitch_cnt !== '0) n_upd++;
        end
        checks++;
        if (n_upd != 0) begin
            errors++; $display("FAIL mid_after got %0d bad cycles want 0", n_upd);
        end
    endtask

    task automatic test_random();
        int seg_left;
        int bad;
        seg_left = 0;
        bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (seg_left == 0) begin
                seg_left = $urandom_range(1, 7);
                if ($urandom_range(0, 3) == 0) din = 4'(m_dout);
                else din = 4'($urandom_range(0, 15));
            end
            seg_left--;
            glitch_clr = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (int'(dout) != m_dout || int'(upd) != m_upd || int'(settling) != m_settling ||
                int'(glitch_cnt) != m_gcnt) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random cyc %0d got dout=%h upd=%b set=%b g=%0d want %h %0d %0d %0d",
                             c, dout, upd, settling, glitch_cnt, m_dout, m_upd, m_settling, m_gcnt);
                bad++;
            end
        end
        rst = 1'b0; glitch_clr = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; din = '0; glitch_clr = 1'b0;
        m_dinq = 0; m_prev = 0; m_run = STABLE; m_dout = 0;
        m_upd = 0; m_settling = 0; m_gcnt = 0;
        test_reset();
        test_clean_step();
        test_short_pulse();
        test_ripple();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
